// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract, split into STAGES carry-chain segments of SEG bits each.
// Latency: STAGES cycles from the accepting edge to out_valid; accepts one beat per cycle.
// Backpressure: the whole pipe advances only when adv = !out_valid || out_ready. in_ready equals adv.
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid/in_ready    - operand handshake (a, b, cin, sub)
//   out_valid/out_ready  - result handshake (sum, cout, ovf)
//   sub=0: sum = a+b+cin ; sub=1: sum = a-b-cin, and cout=1 means no borrow
module adder_pipe #(
  parameter int WIDTH  = 32,  // must be divisible by STAGES
  parameter int STAGES = 4    // 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Every stage moves together, so one advance term covers the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction as a + ~b + ~cin, so a single carry chain serves both operations.
  assign b_eff = sub ? ~b : b;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // Registered state of segment k: valid bit, carry out, and the finished
      // low slices 0..k of this beat (deskew chain).
      logic                 v_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] lo_q;

      logic [SEG-1:0] a_seg;
      logic [SEG-1:0] b_seg;
      logic           c_in;
      logic           v_in;
      logic [SEG:0]   seg_sum;

      assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_in;
          c_q <= seg_sum[SEG];
        end
      end

      if (k == 0) begin : g_head
        assign a_seg = a[SEG-1:0];
        assign b_seg = b_eff[SEG-1:0];
        assign c_in  = sub ? ~cin : cin;
        assign v_in  = in_valid;

        always_ff @(posedge clk) begin
          if (rst) begin
            lo_q <= '0;
          end else if (adv) begin
            lo_q <= seg_sum[SEG-1:0];
          end
        end
      end else begin : g_tail
        // Operand slice k arrives through the skew chain of the previous stage,
        // so it belongs to the same beat as the carry from segment k-1.
        assign a_seg = g_stage[k-1].g_skew.a_sk[SEG-1:0];
        assign b_seg = g_stage[k-1].g_skew.b_sk[SEG-1:0];
        assign c_in  = g_stage[k-1].c_q;
        assign v_in  = g_stage[k-1].v_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            lo_q <= '0;
          end else if (adv) begin
            lo_q <= {seg_sum[SEG-1:0], g_stage[k-1].lo_q};
          end
        end
      end

      if (k < STAGES - 1) begin : g_skew
        // Operand bits not yet consumed; they shrink by one segment per stage.
        logic [WIDTH-(k+1)*SEG-1:0] a_sk;
        logic [WIDTH-(k+1)*SEG-1:0] b_sk;
        logic [WIDTH-(k+1)*SEG-1:0] a_hi;
        logic [WIDTH-(k+1)*SEG-1:0] b_hi;

        if (k == 0) begin : g_src_in
          assign a_hi = a[WIDTH-1:SEG];
          assign b_hi = b_eff[WIDTH-1:SEG];
        end else begin : g_src_prev
          assign a_hi = g_stage[k-1].g_skew.a_sk[WIDTH-k*SEG-1:SEG];
          assign b_hi = g_stage[k-1].g_skew.b_sk[WIDTH-k*SEG-1:SEG];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_sk <= '0;
            b_sk <= '0;
          end else if (adv) begin
            a_sk <= a_hi;
            b_sk <= b_hi;
          end
        end
      end else begin : g_flags
        // Last segment holds the sign bits, so overflow is resolved here.
        logic ovf_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            ovf_q <= 1'b0;
          end else if (adv) begin
            ovf_q <= (a_seg[SEG-1] == b_seg[SEG-1]) && (seg_sum[SEG-1] != a_seg[SEG-1]);
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].lo_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_flags.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (32,4)
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Sweep DUTs share one operand stream and never see backpressure.
  logic        s_valid;
  logic [63:0] s_a, s_b;
  logic        s_cin, s_sub;
  logic        r1_rdy, r1_vld, r1_cout, r1_ovf;
  logic [7:0]  r1_sum;
  logic        r2_rdy, r2_vld, r2_cout, r2_ovf;
  logic [7:0]  r2_sum;
  logic        r3_rdy, r3_vld, r3_cout, r3_ovf;
  logic [63:0] r3_sum;

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_w8s1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r1_rdy),
    .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
    .out_valid(r1_vld), .out_ready(1'b1), .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf)
  );
  adder_pipe #(.WIDTH(8), .STAGES(8)) u_w8s8 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r2_rdy),
    .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .sub(s_sub),
    .out_valid(r2_vld), .out_ready(1'b1), .sum(r2_sum), .cout(r2_cout), .ovf(r2_ovf)
  );
  adder_pipe #(.WIDTH(64), .STAGES(4)) u_w64s4 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r3_rdy),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .out_valid(r3_vld), .out_ready(1'b1), .sum(r3_sum), .cout(r3_cout), .ovf(r3_ovf)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Arithmetic reference in wide signed integers: true sum/difference, then
  // cout from range, ovf from the signed interpretation.
  function automatic exp_t ref_add(int w, logic [63:0] x, logic [63:0] y, logic ci_b, logic sb);
    logic signed [127:0] pw, mask, ux, uy, sx, sy, ci, r, sr;
    exp_t e;
    pw   = 128'sd1 <<< w;
    mask = pw - 128'sd1;
    ux   = $signed({64'd0, x}) & mask;
    uy   = $signed({64'd0, y}) & mask;
    sx   = ux[w-1] ? ux - pw : ux;
    sy   = uy[w-1] ? uy - pw : uy;
    ci   = ci_b ? 128'sd1 : 128'sd0;
    if (sb) begin
      r      = ux - uy - ci;
      sr     = sx - sy - ci;
      e.cout = (r >= 0);
    end else begin
      r      = ux + uy + ci;
      sr     = sx + sy + ci;
      e.cout = (r >= pw);
    end
    e.sum = r[63:0] & mask[63:0];
    e.ovf = (sr >= pw / 2) || (sr < -(pw / 2));
    e.cyc = cyc;
    return e;
  endfunction

  // Bit-serial ripple adder, the behaviour the (8,1) build must reproduce.
  function automatic exp_t ripple8(logic [7:0] x, logic [7:0] y, logic ci, logic sb);
    exp_t e;
    logic c, yb;
    e.sum = '0;
    e.ovf = 1'b0;
    e.cyc = cyc;
    c = ci ^ sb;
    for (int i = 0; i < 8; i++) begin
      yb       = y[i] ^ sb;
      e.sum[i] = x[i] ^ yb ^ c;
      c        = (x[i] & yb) | (c & (x[i] ^ yb));
    end
    e.cout = c;
    return e;
  endfunction

  function automatic exp_t mk(logic [63:0] s, logic c, logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.cyc = 0;
    return e;
  endfunction

  // Main scoreboard
  exp_t qm[$];
  exp_t cur_exp, em;
  int   m_emits = 0, m_gaps = 0, m_prev = -10;

  always @(negedge clk) begin
    if (rst) begin
      qm.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (qm.size() == 0) begin
          check("main_spurious_beat", 64'd1, 64'd0);
        end else begin
          em = qm.pop_front();
          check("main_sum", 64'(sum), em.sum);
          check("main_cout", 64'(cout), 64'(em.cout));
          check("main_ovf", 64'(ovf), 64'(em.ovf));
        end
        m_emits++;
        if (cyc != m_prev + 1) m_gaps++;
        m_prev = cyc;
      end
      if (in_valid && in_ready) qm.push_back(cur_exp);
    end
  end

  // Sweep scoreboards
  exp_t q1[$], q2[$], q3[$];
  exp_t e1, e2, e3, t1, t2;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete(); q2.delete(); q3.delete();
    end else begin
      if (r1_vld) begin
        if (q1.size() == 0) check("w8s1_spurious", 64'd1, 64'd0);
        else begin
          e1 = q1.pop_front();
          check("w8s1_sum", 64'(r1_sum), e1.sum);
          check("w8s1_cout", 64'(r1_cout), 64'(e1.cout));
          check("w8s1_ovf", 64'(r1_ovf), 64'(e1.ovf));
          check("w8s1_latency", 64'(cyc - e1.cyc), 64'd1);
        end
      end
      if (r2_vld) begin
        if (q2.size() == 0) check("w8s8_spurious", 64'd1, 64'd0);
        else begin
          e2 = q2.pop_front();
          check("w8s8_sum", 64'(r2_sum), e2.sum);
          check("w8s8_cout", 64'(r2_cout), 64'(e2.cout));
          check("w8s8_ovf", 64'(r2_ovf), 64'(e2.ovf));
          check("w8s8_latency", 64'(cyc - e2.cyc), 64'd8);
        end
      end
      if (r3_vld) begin
        if (q3.size() == 0) check("w64s4_spurious", 64'd1, 64'd0);
        else begin
          e3 = q3.pop_front();
          check("w64s4_sum", r3_sum, e3.sum);
          check("w64s4_cout", 64'(r3_cout), 64'(e3.cout));
          check("w64s4_ovf", 64'(r3_ovf), 64'(e3.ovf));
          check("w64s4_latency", 64'(cyc - e3.cyc), 64'd4);
        end
      end
      if (s_valid) begin
        t1 = ripple8(s_a[7:0], s_b[7:0], s_cin, s_sub);
        t2 = ref_add(8, s_a, s_b, s_cin, s_sub);
        t1.ovf = t2.ovf;
        if (r1_rdy) q1.push_back(t1);
        if (r2_rdy) q2.push_back(t2);
        if (r3_rdy) q3.push_back(ref_add(64, s_a, s_b, s_cin, s_sub));
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(logic [31:0] ta, logic [31:0] tb_v, logic tcin, logic tsub, exp_t te);
    bit ok;
    a = ta; b = tb_v; cin = tcin; sub = tsub; cur_exp = te;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(logic tsub);
    logic [31:0] ta, tb_v;
    logic        tc;
    ta = $urandom; tb_v = $urandom; tc = 1'($urandom_range(0, 1));
    send(ta, tb_v, tc, tsub, ref_add(32, 64'(ta), 64'(tb_v), tc, tsub));
  endtask

  // Called right after a lone beat's accepting edge: out_valid must rise in the 4th cycle.
  task automatic lat_check(string tag);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check(tag, 64'(out_valid), (i == 4) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic drain(string tag);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (qm.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0) break;
    end
    check(tag, 64'(qm.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  int   n0, g0;
  exp_t eb1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; cur_exp = mk(0, 0, 0);
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Carry ripples across all four segments
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(64'h0, 1'b1, 1'b0));
    lat_check("wrap_latency");
    drain("drain_wrap");

    // Directed flag cases, back to back
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(64'h8000_0000, 1'b0, 1'b1));
    send(32'd5, 32'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0));
    send(32'd7, 32'd5, 1'b1, 1'b1, mk(64'h1, 1'b1, 1'b0));
    drain("drain_directed");

    // Streaming: 16 back-to-back beats, alternating sub
    n0 = m_emits; g0 = m_gaps;
    for (int i = 0; i < 16; i++) send_rand(1'(i % 2));
    drain("drain_stream");
    check("stream_count", 64'(m_emits - n0), 64'd16);
    check("stream_contiguous", 64'(m_gaps - g0), 64'd1);

    // Backpressure with a full pipe
    n0 = m_emits;
    a = $urandom; b = $urandom;
    eb1 = ref_add(32, 64'(a), 64'(b), 1'b1, 1'b0);
    send(a, b, 1'b1, 1'b0, eb1);
    for (int i = 0; i < 3; i++) send_rand(1'(i % 2));
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b0; sub = 1'b1;
    cur_exp = ref_add(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b0, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum_stable", 64'(sum), eb1.sum);
      check("bp_cout_stable", 64'(cout), 64'(eb1.cout));
      check("bp_ovf_stable", 64'(ovf), 64'(eb1.ovf));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1,
         ref_add(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b0, 1'b1));
    send_rand(1'b0);
    drain("drain_bp");
    check("bp_count", 64'(m_emits - n0), 64'd6);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    n0 = m_emits;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("midrst_no_emit", 64'(m_emits - n0), 64'd0);
    @(posedge clk); #1;
    send(32'd1, 32'd2, 1'b0, 1'b0, mk(64'd3, 1'b0, 1'b0));
    lat_check("post_rst_latency");
    drain("drain_post_rst");

    // Parameter sweep with bubbles and carry-boundary corners
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_a     = {$urandom, $urandom};
      s_b     = {$urandom, $urandom};
      s_cin   = 1'($urandom_range(0, 1));
      s_sub   = 1'($urandom_range(0, 1));
      if (i % 8 == 0) begin
        s_a = '1; s_b = 64'd1; s_cin = 1'b0; s_sub = 1'b0;
      end else if (i % 8 == 4) begin
        s_a = '0; s_b = '0; s_cin = 1'b1; s_sub = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain("drain_sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
